// File: rtl/lsio_btn_pkg.sv
// Shared types and helpers for the LSIO push-button bank.
package lsio_btn_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2
  } btn_state_e;

  // Press length in ms scaled down by 'shift' and clamped to a 'width'-bit result.
  function automatic int unsigned scale_sat(input int unsigned ms,
                                            input int unsigned shift,
                                            input int unsigned width);
    int unsigned v;
    int unsigned lim;
    v   = ms >> shift;
    lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/lsio_btn_chan.sv
// One button channel: 2-flop synchroniser, tick-based debouncer, press FSM and
// press statistics that hold until cleared.
module lsio_btn_chan
  import lsio_btn_pkg::*;
#(
  parameter int CUR_W      = 12,
  parameter int DEB_MS     = 8,
  parameter int LONG_W     = 5,
  parameter int LONG_SHIFT = 6,
  parameter int CNT_W      = 4,
  parameter int RESET_MS   = 2048,
  parameter bit RESET_EN   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              tick_i,
  input  logic              btn_i,
  input  logic              clear_i,
  output logic              pressed_o,
  output logic              was_pressed_o,
  output logic [LONG_W-1:0] longest_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              reset_req_o
);

  localparam int DW = $clog2(DEB_MS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);

  logic [1:0]        sync_q, sync_d;
  logic              deb_q, deb_d;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  btn_state_e        state_q, state_d;
  logic [CUR_W-1:0]  press_ms_q, press_ms_d;
  logic              was_q, was_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LONG_W-1:0] longest_q, longest_d;
  logic              req_q, req_d;
  logic              release_evt;
  logic [LONG_W-1:0] scaled;

  always_comb begin
    sync_d      = {sync_q[0], btn_i};
    deb_d       = deb_q;
    deb_cnt_d   = deb_cnt_q;
    state_d     = state_q;
    press_ms_d  = press_ms_q;
    release_evt = 1'b0;
    scaled      = LONG_W'(scale_sat(32'(press_ms_q), LONG_SHIFT, LONG_W));

    if (sync_q[1] == deb_q) begin
      deb_cnt_d = '0;
    end else if (tick_i) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = ~deb_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    case (state_q)
      // Arm only once a released level has been sampled on a tick, so a
      // button held through reset is never counted.
      WAIT_REL: if (!deb_q && !sync_q[1] && tick_i) state_d = IDLE;
      IDLE: begin
        if (deb_q) begin
          state_d    = PRESSED;
          press_ms_d = '0;
        end
      end
      PRESSED: begin
        if (!deb_q) begin
          state_d     = IDLE;
          release_evt = 1'b1;
        end else if (tick_i && (press_ms_q != '1)) begin
          press_ms_d = press_ms_q + 1'b1;
        end
      end
      default: state_d = WAIT_REL;
    endcase

    // Clear is applied first so a coincident release still gets recorded.
    was_d     = clear_i ? 1'b0 : was_q;
    cnt_d     = clear_i ? '0 : cnt_q;
    longest_d = clear_i ? '0 : longest_q;
    req_d     = req_q;
    if (release_evt) begin
      was_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
      if (scaled > longest_d) longest_d = scaled;
      if (RESET_EN && (press_ms_q >= CUR_W'(RESET_MS))) req_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= WAIT_REL;
      press_ms_q <= '0;
      was_q      <= 1'b0;
      cnt_q      <= '0;
      longest_q  <= '0;
      req_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      press_ms_q <= press_ms_d;
      was_q      <= was_d;
      cnt_q      <= cnt_d;
      longest_q  <= longest_d;
      req_q      <= req_d;
    end
  end

  assign pressed_o     = deb_q;
  assign was_pressed_o = was_q;
  assign longest_o     = longest_q;
  assign count_o       = cnt_q;
  assign reset_req_o   = req_q;

endmodule

// File: rtl/lsio_btn_bank.sv
// Multi-channel push-button monitor: per-channel statistics, a sel_i read mux,
// a pending-press interrupt and a sticky long-press reset request.
module lsio_btn_bank
  import lsio_btn_pkg::*;
#(
  parameter int               N_BTN      = 4,
  parameter int               DEB_MS     = 8,
  parameter int               CUR_W      = 12,
  parameter int               LONG_W     = 5,
  parameter int               LONG_SHIFT = 6,
  parameter int               CNT_W      = 4,
  parameter int               RESET_MS   = 2048,
  parameter logic [N_BTN-1:0] RESET_MASK = 'b1
) (
  input  logic                                       clk_i,
  input  logic                                       rstn_i,
  input  logic                                       one_ms_event_i,
  input  logic [N_BTN-1:0]                           btn_i,
  input  logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] sel_i,
  output logic                                       was_pressed_o,
  output logic [LONG_W-1:0]                          longest_press_o,
  output logic [CNT_W-1:0]                           press_count_o,
  output logic [N_BTN-1:0]                           pressed_o,
  input  logic                                       clear_i,
  input  logic                                       clear_all_i,
  output logic                                       irq_o,
  output logic                                       reset_req_o
);

  localparam int SEL_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0]  chan_clr;
  logic [N_BTN-1:0]  was_v;
  logic [N_BTN-1:0]  req_v;
  logic [LONG_W-1:0] long_a [N_BTN];
  logic [CNT_W-1:0]  cnt_a  [N_BTN];

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      assign chan_clr[gi] = clear_all_i | (clear_i & (sel_i == SEL_W'(gi)));

      lsio_btn_chan #(
        .CUR_W      (CUR_W),
        .DEB_MS     (DEB_MS),
        .LONG_W     (LONG_W),
        .LONG_SHIFT (LONG_SHIFT),
        .CNT_W      (CNT_W),
        .RESET_MS   (RESET_MS),
        .RESET_EN   (RESET_MASK[gi])
      ) u_chan (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .tick_i        (one_ms_event_i),
        .btn_i         (btn_i[gi]),
        .clear_i       (chan_clr[gi]),
        .pressed_o     (pressed_o[gi]),
        .was_pressed_o (was_v[gi]),
        .longest_o     (long_a[gi]),
        .count_o       (cnt_a[gi]),
        .reset_req_o   (req_v[gi])
      );
    end
  endgenerate

  // Unpopulated select codes fall through to the all-zero default.
  always_comb begin
    was_pressed_o   = 1'b0;
    longest_press_o = '0;
    press_count_o   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sel_i == SEL_W'(i)) begin
        was_pressed_o   = was_v[i];
        longest_press_o = long_a[i];
        press_count_o   = cnt_a[i];
      end
    end
  end

  assign irq_o       = |was_v;
  assign reset_req_o = |req_v;

endmodule

// File: tb/tb_lsio_btn_bank.sv
// Directed bench for lsio_btn_bank: table of press vectors plus hand-written
// sequences for reset arming, glitches, saturation and clear/release collisions.
module tb_lsio_btn_bank;

  localparam int TCK = 10;  // clocks per 1 ms tick

  typedef struct {
    int ch;
    int hold_ms;
    int exp_long;
    int exp_cnt;
  } press_vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       one_ms = 1'b0;
  logic [3:0] btn = '0;
  logic [1:0] sel = '0;
  logic       clear = 1'b0;
  logic       clear_all = 1'b0;
  logic       was_pressed;
  logic [4:0] longest;
  logic [3:0] count;
  logic [3:0] pressed;
  logic       irq;
  logic       reset_req;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  bit saw_p1 = 1'b0;

  lsio_btn_bank dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .one_ms_event_i  (one_ms),
    .btn_i           (btn),
    .sel_i           (sel),
    .was_pressed_o   (was_pressed),
    .longest_press_o (longest),
    .press_count_o   (count),
    .pressed_o       (pressed),
    .clear_i         (clear),
    .clear_all_i     (clear_all),
    .irq_o           (irq),
    .reset_req_o     (reset_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rstn) begin
      tick_cnt = 0;
      one_ms   = 1'b0;
    end else begin
      one_ms   = (tick_cnt == TCK - 1);
      tick_cnt = (tick_cnt == TCK - 1) ? 0 : tick_cnt + 1;
    end
    if (pressed[1]) saw_p1 = 1'b1;
  end

  task automatic wait_ms(input int n);
    repeat (n * TCK) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", nm, act);
    end
  endtask

  task automatic rd_chk(input string nm, input int ch, input int w, input int l, input int c);
    sel = 2'(ch);
    #1;
    chk({nm, " was"}, 32'(was_pressed), w);
    chk({nm, " longest"}, 32'(longest), l);
    chk({nm, " count"}, 32'(count), c);
  endtask

  task automatic press(input int ch, input int ms);
    btn[ch] = 1'b1;
    wait_ms(ms);
    btn[ch] = 1'b0;
    wait_ms(15);
  endtask

  task automatic pulse_clear(input int ch);
    sel   = 2'(ch);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  press_vec_t vecs [4];
  bit got;

  initial begin
    vecs[0] = '{ch: 2, hold_ms: 200, exp_long: 3, exp_cnt: 1};
    vecs[1] = '{ch: 2, hold_ms: 70,  exp_long: 3, exp_cnt: 2};
    vecs[2] = '{ch: 3, hold_ms: 150, exp_long: 2, exp_cnt: 1};
    vecs[3] = '{ch: 3, hold_ms: 40,  exp_long: 2, exp_cnt: 2};

    // Reset with channel 0 already held
    btn[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset pressed_o", 32'(pressed), 0);
    chk("reset irq_o", 32'(irq), 0);
    chk("reset reset_req_o", 32'(reset_req), 0);
    rd_chk("reset ch0", 0, 0, 0, 0);
    rstn = 1'b1;
    wait_ms(20);
    chk("held ch0 debounced", 32'(pressed[0]), 1);
    btn[0] = 1'b0;
    wait_ms(15);
    rd_chk("held-through-reset ignored", 0, 0, 0, 0);
    press(0, 100);
    rd_chk("ch0 100ms", 0, 1, 1, 1);
    chk("irq after ch0", 32'(irq), 1);
    pulse_clear(0);
    rd_chk("ch0 cleared", 0, 0, 0, 0);
    chk("irq after ch0 clear", 32'(irq), 0);

    // Short glitches on channel 1 must never pass the debouncer
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b1;
      wait_ms(3);
      btn[1] = 1'b0;
      wait_ms(3);
    end
    wait_ms(10);
    chk("glitch pressed_o[1] seen", 32'(saw_p1), 0);
    rd_chk("glitch ch1", 1, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      press(vecs[i].ch, vecs[i].hold_ms);
      rd_chk($sformatf("vec%0d ch%0d", i, vecs[i].ch), vecs[i].ch, 1, vecs[i].exp_long, vecs[i].exp_cnt);
      chk($sformatf("vec%0d irq", i), 32'(irq), 1);
    end
    pulse_clear(2);
    rd_chk("ch2 cleared", 2, 0, 0, 0);
    rd_chk("ch3 untouched by ch2 clear", 3, 1, 2, 2);
    pulse_clear(3);
    #1;
    chk("irq after all clears", 32'(irq), 0);

    // Counter saturation on channel 3
    for (int k = 1; k <= 17; k++) begin
      btn[3] = 1'b1;
      wait_ms(12);
      btn[3] = 1'b0;
      wait_ms(12);
      if (k == 14) rd_chk("ch3 14 presses", 3, 1, 0, 14);
      if (k == 15) rd_chk("ch3 15 presses", 3, 1, 0, 15);
    end
    rd_chk("ch3 17 presses saturated", 3, 1, 0, 15);

    // Long presses: channel 1 masked, channel 0 enabled
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    wait_ms(2100);
    btn[1] = 1'b0;
    wait_ms(15);
    chk("masked long press reset_req", 32'(reset_req), 0);
    rd_chk("ch1 long saturated", 1, 1, 31, 1);
    btn[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 * TCK; k++) begin
      @(negedge clk);
      if (reset_req) begin
        got = 1'b1;
        break;
      end
    end
    chk("ch0 long press reset_req", 32'(got), 1);
    rd_chk("ch0 long saturated", 0, 1, 31, 1);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    #1;
    chk("reset_req sticky through clear_all", 32'(reset_req), 1);
    chk("irq after clear_all", 32'(irq), 0);
    rd_chk("ch0 after clear_all", 0, 0, 0, 0);

    // clear_all on the same cycle as a channel 1 release update
    press(1, 20);
    press(3, 20);
    rd_chk("ch1 before collision", 1, 1, 0, 1);
    btn[1] = 1'b1;
    wait_ms(30);
    btn[1] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 * TCK; k++) begin
      @(negedge clk);
      if (!pressed[1]) begin
        got = 1'b1;
        break;
      end
    end
    chk("ch1 debounced fall seen", 32'(got), 1);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    rd_chk("ch1 clear+release", 1, 1, 0, 1);
    rd_chk("ch3 cleared by clear_all", 3, 0, 0, 0);
    chk("irq after collision", 32'(irq), 1);

    // Only reset clears the reset request
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req after rstn", 32'(reset_req), 0);
    chk("irq after rstn", 32'(irq), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
